// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single Uart transmitter.
// A winner's byte is latched, written once, and acknowledged when the Uart reports busy.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       req0_i,
  input  logic [7:0] data0_i,
  output logic       ack0_o,
  input  logic       req1_i,
  input  logic [7:0] data1_i,
  output logic       ack1_o,
  output logic       error_o,
  output logic       uart_write_o,
  output logic [7:0] uart_data_o,
  input  logic       uart_busy_i
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_e;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     ptr_q, ptr_d;
  logic                     winner_q, winner_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]               data_q, data_d;
  logic                     write_q, write_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic                     error_q, error_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      write_q  <= write_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (!uart_busy_i && (req0_i || req1_i)) begin
          // pointer only breaks ties; a lone requester always wins
          winner_d = (req0_i && req1_i) ? ptr_q : req1_i;
          data_d   = winner_d ? data1_i : data0_i;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (uart_busy_i) begin
          ptr_d   = ~winner_q;
          state_d = WAIT_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          ptr_d   = ~winner_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_d = (state_d == ISSUE);
    ack0_d  = (state_q == ISSUE) && uart_busy_i && !winner_q;
    ack1_d  = (state_q == ISSUE) && uart_busy_i && winner_q;
    error_d = (state_q == ISSUE) && !uart_busy_i && (cnt_q == TIMEOUT_LAST);
  end

  assign uart_write_o = write_q;
  assign uart_data_o  = data_q;
  assign ack0_o       = ack0_q;
  assign ack1_o       = ack1_q;
  assign error_o      = error_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_WIDTH, default 8: width of the busy-acknowledge timeout counter.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles in ISSUE without uart_busy_i before abort.
REQ-003 SHALL have port clock_i, input, 1: single clock; all logic on posedge clock_i.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req0_i, input, 1: requester 0 byte request (level).
REQ-006 SHALL have port data0_i, input, 8: requester 0 byte.
REQ-007 SHALL have port ack0_o, output, 1: one-cycle pulse, requester 0 byte accepted by Uart.
REQ-008 SHALL have ports req1_i (1), data1_i (8) and ack1_o (1) as input/input/output: requester 1, same semantics.
REQ-009 SHALL have port error_o, output, 1: one-cycle pulse on timeout abort.
REQ-010 SHALL have port uart_write_o, output, 1: drives Uart write_i.
REQ-011 SHALL have port uart_data_o, output, 8: drives Uart data_i.
REQ-012 SHALL have port uart_busy_i, input, 1: from Uart write_busy_o.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE.
REQ-014 In IDLE with uart_busy_i=0 and at least one request: SHALL select a winner, latch its data into uart_data_o, go to ISSUE next cycle.
REQ-015 In IDLE with uart_busy_i=1: SHALL NOT grant; requests wait.
REQ-016 Arbitration SHALL be round-robin: 1-bit priority pointer, reset 0; with both requesting, pointer's requester wins; pointer SHALL move to the other requester after each grant that completes or aborts.
REQ-017 With a single requester, that requester SHALL win regardless of pointer; pointer still updates per REQ-016.
REQ-018 uart_write_o SHALL be 1 exactly while in ISSUE; latency from req sampled in IDLE to uart_write_o=1 is 1 cycle.
REQ-019 uart_data_o SHALL hold the latched byte unchanged from ISSUE entry through WAIT_DONE exit; later changes on dataN_i SHALL NOT affect it.
REQ-020 In ISSUE, when uart_busy_i=1: SHALL pulse winner's ackN_o for exactly one cycle and go to WAIT_DONE.
REQ-021 In ISSUE, timeout counter SHALL increment per cycle from 0; on reaching TIMEOUT_CYCLES without uart_busy_i: pulse error_o one cycle, no ackN_o, go to IDLE, advance pointer.
REQ-022 In WAIT_DONE: SHALL stay until uart_busy_i=0, then go to IDLE; next grant earliest the following cycle.
REQ-023 A requester dropping reqN_i after grant SHALL NOT cancel the transfer.
REQ-024 A requester holding reqN_i after its ack SHALL be treated as a new request (one byte per grant).
REQ-025 ack0_o, ack1_o and error_o SHALL be mutually exclusive and never high together.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 With reset_i=1 at a clock edge: state=IDLE, pointer=0, timeout counter=0, uart_write_o=0, uart_data_o=8'h00, ack0_o=0, ack1_o=0, error_o=0 at the next edge.
REQ-028 Reset asserted mid-transfer (ISSUE or WAIT_DONE) SHALL abort without any ack or error pulse.

Verification
REQ-029 Single request: req0_i=1, data0_i=8'hA5, Uart model raises busy 2 cycles after write -> uart_write_o high 1 cycle after req, uart_data_o=8'hA5, ack0_o one pulse, return to IDLE after busy falls.
REQ-030 Contention: req0_i=req1_i=1 held, data 8'h11/8'h22 -> Uart receives 11,22,11,22 in order; acks alternate 0,1,0,1.
REQ-031 Busy at request: uart_busy_i=1 when req1_i rises -> no uart_write_o until busy=0; then grant within 1 cycle.
REQ-032 Timeout: TIMEOUT_CYCLES=4, uart_busy_i held 0 -> uart_write_o high 4 cycles, error_o one pulse, no ack, pointer advanced.
REQ-033 Data stability: change data0_i from 8'h3C to 8'hFF during ISSUE -> uart_data_o remains 8'h3C until WAIT_DONE exits.
REQ-034 Reset mid-transfer: reset_i=1 during WAIT_DONE -> all outputs 0 next cycle, no ack/error; req1_i afterwards granted first only if req0_i low.
